// File: rtl/qint_multi.sv
// qint_multi: multi-channel QBUS interrupt requester with level arbitration and IAK daisy chain.
// Optional QINT_MASK_EN adds the int_mask port (masked channels stay pending but are ineligible).
module qint_multi #(
    parameter int NCHAN       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2*NCHAN-1:0] int_priority,
    input  logic               RINIT,
    input  logic               RDIN,
    input  logic               RIAKI,
    input  logic [4:7]         RIRQ,
    input  logic [NCHAN-1:0]   int_request,
`ifdef QINT_MASK_EN
    input  logic [NCHAN-1:0]   int_mask,
`endif
    output logic [4:7]         TIRQ,
    output logic               TIAKO,
    output logic               assert_vector,
    output logic [CW-1:0]      vector_chan
);
    localparam logic [1:0] INTP_4 = 2'd0;
    localparam logic [1:0] INTP_5 = 2'd1;
    localparam logic [1:0] INTP_6 = 2'd2;
    localparam logic [1:0] INTP_7 = 2'd3;

    typedef enum logic [1:0] {IDLE, ARMED, VECTOR} state_t;
    state_t state, state_n;

    logic [6:0]       sync_q [SYNC_STAGES];
    logic             rinit_s, rdin_s, riaki_s, rdin_q, riaki_q;
    logic [4:7]       rirq_s;
    logic             unused_rirq4;
    logic [NCHAN-1:0] req_q, pending, elig, clr;
    logic [4:7]       tirq_d;
    logic             has_win, irq_higher, latch, ack;
    logic [CW-1:0]    win_idx;
    logic [1:0]       win_lvl;

    assign {rinit_s, rdin_s, riaki_s, rirq_s} = sync_q[SYNC_STAGES-1];
    assign unused_rirq4 = rirq_s[4];
    assign clr = ack ? (NCHAN'(1) << vector_chan) : '0;

`ifdef QINT_MASK_EN
    assign elig = pending & ~int_mask;
`else
    assign elig = pending;
`endif

    // Highest level wins; strict '>' keeps ties on the lowest index.
    always_comb begin
        has_win = 1'b0;
        win_idx = '0;
        win_lvl = INTP_4;
        tirq_d  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (elig[i]) begin
                tirq_d[4] = 1'b1;
                tirq_d[5] = tirq_d[5] | (int_priority[2*i +: 2] == INTP_5);
                tirq_d[6] = tirq_d[6] | int_priority[2*i+1];
                tirq_d[7] = tirq_d[7] | (int_priority[2*i +: 2] == INTP_7);
                if (!has_win || int_priority[2*i +: 2] > win_lvl) begin
                    has_win = 1'b1;
                    win_lvl = int_priority[2*i +: 2];
                    win_idx = CW'(i);
                end
            end
        end
    end

    // Our own drivers are removed from the bus view before comparing.
    assign irq_higher = (win_lvl == INTP_4) ? ((rirq_s[5] & ~TIRQ[5]) | (rirq_s[6] & ~TIRQ[6])) :
                        (win_lvl == INTP_5) ? (rirq_s[6] & ~TIRQ[6]) :
                        (win_lvl == INTP_6) ? (rirq_s[7] & ~TIRQ[7]) : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        ack     = 1'b0;
        if (rinit_s) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (rdin_s && !rdin_q && has_win && !irq_higher) begin
                    state_n = ARMED;
                    latch   = 1'b1;
                end
                ARMED: if (riaki_s && !riaki_q) begin
                    state_n = VECTOR;
                    ack     = 1'b1;
                end else if (rdin_s && !rdin_q && !riaki_s) begin
                    state_n = IDLE;
                end
                VECTOR: if (!riaki_s && riaki_q) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // req_q resets high so a request already asserted through reset is not taken as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            rdin_q        <= 1'b0;
            riaki_q       <= 1'b0;
            req_q         <= '1;
            pending       <= '0;
            vector_chan   <= '0;
            TIRQ          <= '0;
            TIAKO         <= 1'b0;
            assert_vector <= 1'b0;
        end else begin
            sync_q[0] <= {RINIT, RDIN, RIAKI, RIRQ};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            rdin_q  <= rdin_s;
            riaki_q <= riaki_s;
            req_q   <= int_request;
            if (rinit_s) begin
                pending       <= '0;
                vector_chan   <= '0;
                TIRQ          <= '0;
                TIAKO         <= 1'b0;
                assert_vector <= 1'b0;
            end else begin
                pending       <= (pending & ~clr) | (int_request & ~req_q);
                vector_chan   <= latch ? win_idx : vector_chan;
                TIRQ          <= tirq_d;
                TIAKO         <= riaki_s && (state_n == IDLE);
                assert_vector <= (state_n == VECTOR);
            end
        end
    end
endmodule

// File: tb/tb_qint_multi.sv
// tb_qint_multi: scoreboard bench for qint_multi; expected vector channels are queued per acknowledge.
// Define QINT_MASK_EN to also exercise the mask port.
module tb_qint_multi;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset_n, RINIT, RDIN, RIAKI;
    logic [4:7] RIRQ;
    logic [7:0] int_priority;
    logic [3:0] int_request;
    logic [3:0] int_mask;
    logic [4:7] TIRQ;
    logic       TIAKO, assert_vector;
    logic [1:0] vector_chan;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];
    bit av_q = 1'b0;

    qint_multi #(.NCHAN(4), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .int_priority(int_priority),
        .RINIT(RINIT), .RDIN(RDIN), .RIAKI(RIAKI), .RIRQ(RIRQ),
        .int_request(int_request),
`ifdef QINT_MASK_EN
        .int_mask(int_mask),
`endif
        .TIRQ(TIRQ), .TIAKO(TIAKO), .assert_vector(assert_vector), .vector_chan(vector_chan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input int ch);
        int_request[ch] = 1'b1;
        tick(1);
        int_request[ch] = 1'b0;
        tick(1);
    endtask

    task automatic din();
        RDIN = 1'b1;
        tick(4);
        RDIN = 1'b0;
        tick(4);
    endtask

    task automatic wait_av(output bit got, output bit tiako_seen);
        got = 1'b0;
        tiako_seen = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            tick(1);
            got = assert_vector;
            tiako_seen |= TIAKO;
        end
        if (!got) begin
            check("ack_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    task automatic ack(input int ch, input int mid);
        bit got, seen;
        sb.push_back(ch);
        RIAKI = 1'b1;
        wait_av(got, seen);
        if (got && mid >= 0) pulse_req(mid);
        RIAKI = 1'b0;
        repeat (5) begin
            tick(1);
            seen |= TIAKO;
        end
        check("tiako_low", seen, 0);
    endtask

    // Scoreboard consumer: every assert_vector rising edge must match the oldest expectation.
    always @(negedge clk) begin
        if (assert_vector && !av_q) begin
            if (sb.size() == 0) check("sb_unexpected", 1, 0);
            else check("vector_chan", vector_chan, sb.pop_front());
        end
        if (TIAKO && assert_vector) check("tiako_av_excl", 1, 0);
        av_q = assert_vector;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got, seen;
        reset_n = 1'b1; RINIT = 1'b0; RDIN = 1'b0; RIAKI = 1'b0; RIRQ = '0;
        int_request = '0; int_mask = '0;
        int_priority = 8'b10_01_01_00;
        #2 reset_n = 1'b0;
        #1;
        check("rst_tirq", TIRQ, 0);
        check("rst_tiako", TIAKO, 0);
        check("rst_av", assert_vector, 0);
        check("rst_vchan", vector_chan, 0);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("idle_tirq", TIRQ, 0);

        pulse_req(2);
        tick(1);
        check("t1_tirq", TIRQ, 4'b1100);
        din();
        ack(2, -1);
        check("t1_cleared", TIRQ, 0);

        pulse_req(0);
        pulse_req(3);
        tick(1);
        check("t2_tirq", TIRQ, 4'b1010);
        din();
        ack(3, -1);
        check("t2_rest", TIRQ, 4'b1000);
        din();
        ack(0, -1);
        check("t2_cleared", TIRQ, 0);

        pulse_req(1);
        tick(1);
        RIRQ = 4'b0010;
        din();
        RIAKI = 1'b1;
        tick(SS + 1);
        check("t3_tiako", TIAKO, 1);
        check("t3_av", assert_vector, 0);
        RIAKI = 1'b0;
        tick(4);
        check("t3_tiako_off", TIAKO, 0);
        check("t3_pending", TIRQ, 4'b1100);
        RIRQ = '0;
        din();
        ack(1, -1);

        pulse_req(2);
        pulse_req(1);
        din();
        ack(1, -1);
        din();
        ack(2, -1);

        pulse_req(2);
        pulse_req(2);
        din();
        ack(2, -1);
        tick(1);
        check("absorb", TIRQ, 0);

        pulse_req(0);
        din();
        pulse_req(3);
        ack(0, -1);
        check("latched_keep", TIRQ, 4'b1010);
        din();
        ack(3, -1);

        pulse_req(1);
        din();
        ack(1, 2);
        check("vector_retain", TIRQ, 4'b1100);
        din();
        ack(2, -1);

        pulse_req(0);
        pulse_req(3);
        din();
        sb.push_back(3);
        RIAKI = 1'b1;
        wait_av(got, seen);
        RINIT = 1'b1;
        int_request[1] = 1'b1;
        tick(SS + 1);
        check("rinit_av", assert_vector, 0);
        check("rinit_tirq", TIRQ, 0);
        check("rinit_vchan", vector_chan, 0);
        RIAKI = 1'b0;
        int_request[1] = 1'b0;
        tick(2);
        RINIT = 1'b0;
        tick(SS + 3);
        check("rinit_pending", TIRQ, 0);

`ifdef QINT_MASK_EN
        int_mask = 4'b0001;
        pulse_req(0);
        tick(1);
        check("mask_tirq", TIRQ, 0);
        int_mask = 4'b0000;
        tick(1);
        check("unmask_tirq", TIRQ, 4'b1000);
        din();
        ack(0, -1);
`endif

        tick(2);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
